// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the tagged split-transaction memory responder.
package mem_responder_pkg;

    localparam int unsigned MEM_TAG_W    = 4;
    localparam int unsigned MEM_NUM_TAGS = 15;
    localparam int unsigned MEM_BLOCK_W  = 64;
    // Countdown width; wide enough for any practical latency.
    localparam int unsigned MEM_COUNT_W  = 16;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_cmd_e;

    typedef struct packed {
        logic                   valid;
        logic [MEM_COUNT_W-1:0] count;
        logic [MEM_BLOCK_W-1:0] data;
    } mem_entry_t;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response/return bus.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [1:0]             proc2mem_command;
    logic [31:0]            proc2mem_addr;
    logic [MEM_BLOCK_W-1:0] proc2mem_data;
    logic [MEM_TAG_W-1:0]   mem2proc_response;
    logic [MEM_BLOCK_W-1:0] mem2proc_data;
    logic [MEM_TAG_W-1:0]   mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_tag_alloc.sv
// Free list of transaction tags 1..15 with lowest-free-first allocation.
module mem_tag_alloc
    import mem_responder_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_req,
    output logic [MEM_TAG_W-1:0] alloc_tag,
    output logic                 alloc_ok,
    input  logic                 free_en,
    input  logic [MEM_TAG_W-1:0] free_tag
);

    logic [MEM_NUM_TAGS:1] free_q, free_d;

    // Priority encoder: scan downwards so the lowest free tag wins.
    always_comb begin
        alloc_tag = '0;
        alloc_ok  = 1'b0;
        for (int t = MEM_NUM_TAGS; t >= 1; t--) begin
            if (free_q[t]) begin
                alloc_tag = MEM_TAG_W'(t);
                alloc_ok  = 1'b1;
            end
        end
    end

    // Next free vector: release the completing tag, claim the granted one.
    always_comb begin
        free_d = free_q;
        if (free_en && free_tag != '0) begin
            free_d[free_tag] = 1'b1;
        end
        if (alloc_req && alloc_ok) begin
            free_d[alloc_tag] = 1'b0;
        end
    end

    // Free vector register; every tag free after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: accepts tagged requests and returns each block after a fixed latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LATENCY   = 20,
    parameter int unsigned MEM_ADDR_BITS = 13
) (
    input  logic            clock,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int unsigned NumLines = 2 ** MEM_ADDR_BITS;

    logic [MEM_BLOCK_W-1:0]   mem_q [NumLines];
    mem_entry_t               entry_q [1:MEM_NUM_TAGS];
    mem_entry_t               entry_d [1:MEM_NUM_TAGS];
    logic [MEM_TAG_W-1:0]     ret_tag_q, ret_tag_d;
    logic [MEM_BLOCK_W-1:0]   ret_data_q, ret_data_d;

    logic [MEM_ADDR_BITS-1:0] line;
    logic                     is_load, is_store, in_range;
    logic                     alloc_req, alloc_ok, accept;
    logic [MEM_TAG_W-1:0]     alloc_tag;
    logic [MEM_BLOCK_W-1:0]   load_data, snap_data;

    assign line      = bus.proc2mem_addr[MEM_ADDR_BITS+2:3];
    assign is_load   = bus.proc2mem_command == MEM_LOAD;
    assign is_store  = bus.proc2mem_command == MEM_STORE;
    assign in_range  = (bus.proc2mem_addr >> (MEM_ADDR_BITS + 3)) == '0;
    assign alloc_req = (is_load || is_store) && in_range && !reset;
    assign accept    = alloc_req && alloc_ok;
    assign load_data = mem_q[line];
    // Stores complete with an all-zero block.
    assign snap_data = is_load ? load_data : '0;

    assign bus.mem2proc_response = accept ? alloc_tag : '0;
    assign bus.mem2proc_tag      = ret_tag_q;
    assign bus.mem2proc_data     = ret_data_q;

    // The tag on the return bus is released one edge later, so it is never re-granted
    // in the same cycle it is being returned.
    mem_tag_alloc u_tag_alloc (
        .clock     (clock),
        .reset     (reset),
        .alloc_req (alloc_req),
        .alloc_tag (alloc_tag),
        .alloc_ok  (alloc_ok),
        .free_en   (ret_tag_q != '0),
        .free_tag  (ret_tag_q)
    );

    // Backing store write on an accepted STORE; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem_q[line] <= bus.proc2mem_data;
        end
    end

    // Age in-flight entries, pick the one whose countdown reaches 0, and enqueue new work.
    always_comb begin
        entry_d    = entry_q;
        ret_tag_d  = '0;
        ret_data_d = '0;
        for (int t = 1; t <= MEM_NUM_TAGS; t++) begin
            if (entry_q[t].valid) begin
                if (entry_q[t].count == MEM_COUNT_W'(1)) begin
                    ret_tag_d        = MEM_TAG_W'(t);
                    ret_data_d       = entry_q[t].data;
                    entry_d[t].valid = 1'b0;
                    entry_d[t].count = '0;
                end else begin
                    entry_d[t].count = entry_q[t].count - MEM_COUNT_W'(1);
                end
            end
        end
        if (accept) begin
            if (MEM_LATENCY == 1) begin
                // Countdown starts at 0: the request leaves on its accepting edge.
                ret_tag_d  = alloc_tag;
                ret_data_d = snap_data;
            end else begin
                entry_d[alloc_tag].valid = 1'b1;
                entry_d[alloc_tag].count = MEM_COUNT_W'(MEM_LATENCY - 1);
                entry_d[alloc_tag].data  = snap_data;
            end
        end
    end

    // In-flight entries and return register; reset drops all outstanding work.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 1; t <= MEM_NUM_TAGS; t++) begin
                entry_q[t] <= '0;
            end
            ret_tag_q  <= '0;
            ret_data_q <= '0;
        end else begin
            entry_q    <= entry_d;
            ret_tag_q  <= ret_tag_d;
            ret_data_q <= ret_data_d;
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable main-memory responder for the instruction and data caches. It answers the tagged split-transaction memory protocol that the caches drive. Every accepted request immediately gets a non-zero transaction tag. After a fixed latency, the block broadcasts that tag together with the 64-bit block on the return bus. Tag 0 always means "no transaction": on the response port it marks a rejected request, and on the return bus it marks an idle cycle.

## Interface
Parameters:
- MEM_LATENCY, default 20: cycles from acceptance to return; must be ≥1; may exceed the 15 available tags.
- MEM_ADDR_BITS, default 13: number of 64-bit lines in backing store is 2^MEM_ADDR_BITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- proc2mem_command  in  2  command: 0 NONE, 1 LOAD, 2 STORE, 3 reserved (treated as NONE).
- proc2mem_addr  in  32  byte address.
- proc2mem_data  in  64  store data.
- mem2proc_response  out  4  tag allocated this cycle; 0 means rejected or idle; combinational.
- mem2proc_data  out  64  returned block; registered.
- mem2proc_tag  out  4  completing tag; 0 means idle; registered.

## Operation
- Tags 1..15 are kept in a free list. On a valid command, the block allocates the lowest free tag and drives it on mem2proc_response in the same cycle.
- A request is rejected (response 0, no side effects) when:
  - no tag is free; or
  - proc2mem_addr[31:MEM_ADDR_BITS+3] is non-zero (out of range).
- Address mapping: line index is addr[MEM_ADDR_BITS+2:3]; addr[2:0] is ignored.
- LOAD: the line is read at the accepting edge and snapshotted into the tag's in-flight entry. A later STORE to the same line does not affect an in-flight LOAD.
- STORE: the backing store is written at the accepting edge. The tag still occupies MEM_LATENCY cycles and completes with mem2proc_data = 0.
- Each in-flight entry holds valid, a countdown, and 64-bit data. The countdown is loaded with MEM_LATENCY−1 on acceptance and decremented each cycle.
- When an entry's countdown is 0, the next edge registers it onto mem2proc_tag/mem2proc_data and frees the tag.
- There is at most one accept per cycle and latency is fixed, so at most one entry expires per cycle. The bench asserts this.
- In cycles with no completion, mem2proc_tag = 0 and mem2proc_data = 0.

## Timing
- Reset values:
  - mem2proc_tag = 0, mem2proc_data = 0.
  - mem2proc_response = 0 while reset is high.
  - All tags free; all in-flight entries cleared.
  - Backing store is NOT cleared; it is preloaded by the bench.
- Request accepted in cycle N → mem2proc_tag equals that tag during cycle N+MEM_LATENCY.
- A freed tag is allocatable from cycle N+MEM_LATENCY+1 onward. A tag never appears on mem2proc_response in the same cycle it appears on mem2proc_tag.
- Simultaneous completion and new request: the new request sees the free list as it was before this cycle's completion.
- Reset mid-operation discards all in-flight transactions. No stale tag is ever returned after reset deasserts.
- Read-after-write: a STORE accepted in cycle N is visible to a LOAD accepted in cycle N+1.
- Throughput: one request per cycle. With MEM_LATENCY > 15, the 16th consecutive request is rejected.

## Structure
- Shared package contents:
  - Command enum (MEM_NONE/MEM_LOAD/MEM_STORE).
  - MEM_TAG_W = 4, MEM_NUM_TAGS = 15, MEM_BLOCK_W = 64.
  - In-flight entry struct {valid, count, data}.
- Sub-module mem_tag_alloc:
  - 15-bit free vector with lowest-free priority encoder.
  - alloc_req/alloc_tag/alloc_ok interface, plus free_en/free_tag.
- Top level holds the backing-store array, the 15 in-flight entries, and the return register.

## Test plan
- Line 5 preloaded 0xDEAD_BEEF; LOAD addr 0x28 in cycle 0 → response 1 in cycle 0; tag 1 with data 0xDEAD_BEEF in cycle 20; tag 0 in cycles 1–19 and 21.
- STORE addr 0x40 data 0x1234 in cycle 0, LOAD 0x40 in cycle 1 → responses 1, 2; tag 2 returns 0x1234 in cycle 21.
- LOAD 0x40 in cycle 0, STORE 0x40 data 0x5555 in cycle 1 → tag 1 returns the old value in cycle 20.
- 16 LOADs in cycles 0–15 → responses 1..15, then 0 in cycle 15. A retried LOAD in cycle 21 → response 1 (tag 1 freed after cycle 20); not granted in cycle 20.
- LOAD addr 0x0010_0000 (MEM_ADDR_BITS=13) → response 0; no return for the full latency window.
- Three LOADs accepted, reset pulsed in cycle 5 → mem2proc_tag stays 0 through cycle 40; the next LOAD gets response 1.
